mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between two requesters: CPU instruction fetch (I-port, read-only, 24-bit words) and data LD/ST (D-port, 16-bit).
- Sits between the CPU core and the memory block. Sequences every access as request → memory handshake → one-cycle acknowledge.
- Enforces data-over-fetch priority and a bus timeout, so a hung memory cannot lock the core.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_timer.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// port-select constants and default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 24;
  localparam int DATA_W  = 16;

  // Width of the bus-timeout counter; TIMEOUT must fit (1..255).
  localparam int TMR_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-timeout counter for the arbiter. Held at zero while clr_i is high,
// counts every cycle en_i is high. expired_o flags the cycle whose count
// would reach TIMEOUT, so the access is aborted after exactly TIMEOUT
// waiting cycles.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  import mem_arb_pkg::*;

  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the instruction-fetch
// port (read-only, INSTR_W wide) and the data load/store port (DATA_W wide).
// Each access: IDLE grant -> BUSY until mem_ready or timeout -> one-cycle ACK.
// Data requests win over fetches. Defining MEM_ARB_STARVE_GUARD_EN adds a
// starvation guard that forces a fetch grant after STARVE_LIMIT consecutive
// data grants that overtook a pending fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
  parameter int INSTR_W      = mem_arb_pkg::INSTR_W,
  parameter int DATA_W       = mem_arb_pkg::DATA_W,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ack,
  output logic               i_err,
  output logic [INSTR_W-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_ack,
  output logic               d_err,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata
);
  import mem_arb_pkg::*;

  arb_state_e         state_q;
  logic               i_ack_q;
  logic               i_err_q;
  logic [INSTR_W-1:0] i_rdata_q;
  logic               d_ack_q;
  logic               d_err_q;
  logic [DATA_W-1:0]  d_rdata_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;

  logic grant_sel;
  logic starve_hit;
  logic busy;
  logic tmr_expired;

  assign busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == ST_IDLE),
    .en_i      (busy && !mem_ready),
    .expired_o (tmr_expired)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  assign starve_hit = (starve_q == STARVE_MAX);

  // Count data grants that overtook a waiting fetch; a fetch grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if ((grant_sel == PORT_I) && i_req) begin
        starve_d = '0;
      end else if ((grant_sel == PORT_D) && d_req && i_req && !starve_hit) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_hit          = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Priority select: data first, unless the starvation guard forces a fetch.
  always_comb begin
    grant_sel = PORT_I;
    if (d_req && !(starve_hit && i_req)) begin
      grant_sel = PORT_D;
    end
  end

  // Access sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (d_req || i_req) begin
            mem_req_q <= 1'b1;
            if (grant_sel == PORT_D) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= INSTR_W'(d_wdata);
              state_q     <= ST_BUSY_D;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
              state_q     <= ST_BUSY_I;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // A timeout only fires while mem_ready is low, so !mem_ready is the error flag.
          if (mem_ready || tmr_expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_ACK;
            if (state_q == ST_BUSY_I) begin
              i_ack_q   <= 1'b1;
              i_err_q   <= !mem_ready;
              i_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_err_q   <= !mem_ready;
              d_rdata_q <= (mem_ready && !mem_we_q) ? mem_rdata[DATA_W-1:0] : '0;
            end
          end
        end
        ST_ACK: begin
          i_ack_q <= 1'b0;
          i_err_q <= 1'b0;
          d_ack_q <= 1'b0;
          d_err_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [23:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ready;
  logic [23:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_err     (i_err),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int cnt;
    logic exp_d;

    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_i_ack", 32'(i_ack), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    rst = 1'b0;
    step();

    // Zero-wait fetch
    i_req = 1'b1; i_addr = 16'h0010; mem_ready = 1'b1; mem_rdata = 24'hABCDEF;
    step();
    chk("f_mem_req", 32'(mem_req), 32'h1);
    chk("f_mem_addr", 32'(mem_addr), 32'h0010);
    chk("f_mem_we", 32'(mem_we), 32'h0);
    chk("f_ack_early", 32'(i_ack), 32'h0);
    step();
    chk("f_mem_req_drop", 32'(mem_req), 32'h0);
    chk("f_i_ack", 32'(i_ack), 32'h1);
    chk("f_i_rdata", 32'(i_rdata), 32'hABCDEF);
    chk("f_i_err", 32'(i_err), 32'h0);
    i_req = 1'b0; mem_ready = 1'b0;
    step();
    chk("f_ack_pulse", 32'(i_ack), 32'h0);

    // Store with 3 wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_rdata = 24'h55AA55;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("st_mem_req", 32'(mem_req), 32'h1);
      chk("st_mem_we", 32'(mem_we), 32'h1);
      chk("st_mem_addr", 32'(mem_addr), 32'h0200);
      chk("st_mem_wdata", 32'(mem_wdata), 32'h001234);
      chk("st_no_ack", 32'(d_ack), 32'h0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    chk("st_d_ack", 32'(d_ack), 32'h1);
    chk("st_d_err", 32'(d_err), 32'h0);
    chk("st_d_rdata", 32'(d_rdata), 32'h0);
    chk("st_mem_req_drop", 32'(mem_req), 32'h0);
    chk("st_mem_we_drop", 32'(mem_we), 32'h0);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    step();
    chk("st_ack_pulse", 32'(d_ack), 32'h0);

    // Simultaneous requests: D load then I fetch
    i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    mem_ready = 1'b1; mem_rdata = 24'h12BEEF;
    step();
    chk("sim_d_addr", 32'(mem_addr), 32'h0300);
    chk("sim_d_we", 32'(mem_we), 32'h0);
    step();
    chk("sim_d_ack", 32'(d_ack), 32'h1);
    chk("sim_d_rdata", 32'(d_rdata), 32'hBEEF);
    chk("sim_no_i_ack", 32'(i_ack), 32'h0);
    d_req = 1'b0;
    step();
    chk("sim_idle_req", 32'(mem_req), 32'h0);
    step();
    chk("sim_i_req", 32'(mem_req), 32'h1);
    chk("sim_i_addr", 32'(mem_addr), 32'h0040);
    mem_rdata = 24'h777777;
    step();
    chk("sim_i_ack", 32'(i_ack), 32'h1);
    chk("sim_i_rdata", 32'(i_rdata), 32'h777777);
    chk("sim_no_d_ack", 32'(d_ack), 32'h0);
    i_req = 1'b0; mem_ready = 1'b0;
    step();

    // Timeout on a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400; mem_rdata = 24'hFFFFFF;
    step();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 300) begin
      cnt++;
      step();
    end
    chk("to_busy_cycles", 32'(cnt), 32'd255);
    chk("to_d_ack", 32'(d_ack), 32'h1);
    chk("to_d_err", 32'(d_err), 32'h1);
    chk("to_d_rdata", 32'(d_rdata), 32'h0);
    d_req = 1'b0;
    step();
    chk("to_ack_pulse", 32'(d_ack), 32'h0);
    chk("to_err_pulse", 32'(d_err), 32'h0);
    step();
    chk("to_idle_req", 32'(mem_req), 32'h0);

    // Both requests held continuously: grant order
    i_req = 1'b1; i_addr = 16'h0A00; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0D00;
    mem_ready = 1'b1; mem_rdata = 24'h000001;
    for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_d = ((g % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      step();
      chk($sformatf("pr_grant_addr%0d", g), 32'(mem_addr), exp_d ? 32'h0D00 : 32'h0A00);
      step();
      chk($sformatf("pr_d_ack%0d", g), 32'(d_ack), 32'(exp_d));
      chk($sformatf("pr_i_ack%0d", g), 32'(i_ack), 32'(!exp_d));
      step();
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0500; d_wdata = 16'hCAFE;
    step();
    chk("rb_mem_req", 32'(mem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rb_async_req", 32'(mem_req), 32'h0);
    chk("rb_async_we", 32'(mem_we), 32'h0);
    chk("rb_async_addr", 32'(mem_addr), 32'h0);
    chk("rb_async_wdata", 32'(mem_wdata), 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rb_no_ack0", 32'(d_ack), 32'h0);
    step();
    chk("rb_no_ack1", 32'(d_ack), 32'h0);
    i_req = 1'b1; i_addr = 16'h0600; mem_ready = 1'b1; mem_rdata = 24'h13579B;
    step();
    chk("rb_new_req", 32'(mem_req), 32'h1);
    chk("rb_new_addr", 32'(mem_addr), 32'h0600);
    step();
    chk("rb_new_ack", 32'(i_ack), 32'h1);
    chk("rb_new_rdata", 32'(i_rdata), 32'h13579B);
    i_req = 1'b0; mem_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
